// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : divider_seq
//  Description : Sequential unsigned restoring divider, N-bit. One quotient
//                bit per clock via shift-and-subtract. Start/Done handshake,
//                Busy while iterating. Division by zero completes at once
//                with an all-ones quotient, the dividend as remainder and
//                the DivByZero flag set.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_seq #(
   parameter int N = 8
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         Busy,
   output logic         Done,
   output logic [N-1:0] Quotient,
   output logic [N-1:0] Remainder,
   output logic         DivByZero
);

   // Iteration counter only needs to reach N-1; the Nth RUN edge completes.
   localparam int                 c_CNT_W = (N > 2) ? $clog2(N) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t             r_state;
   logic [N-1:0]       r_q;      // dividend shifting out, quotient shifting in
   logic [N-1:0]       r_div;    // divisor latched at acceptance
   logic [N-1:0]       r_p;      // partial remainder
   logic [c_CNT_W-1:0] r_cnt;

   // The partial remainder is conceptually N+1 bits wide, but after each
   // restore it is strictly below the divisor, so its top bit is always
   // zero between iterations. Only the shifted value needs the extra bit.
   logic [N:0]         w_shift;
   logic [N:0]         w_trial;
   logic               w_fits;
   logic [N-1:0]       w_p_next;
   logic [N-1:0]       w_q_next;

   // One restoring iteration: shift {P,Q} left, trial-subtract the divisor.
   always_comb begin
      w_shift  = {r_p, r_q[N-1]};
      w_trial  = w_shift - {1'b0, r_div};
      w_fits   = ~w_trial[N];
      w_p_next = w_fits ? w_trial[N-1:0] : w_shift[N-1:0];
      w_q_next = {r_q[N-2:0], w_fits};
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_q       <= '0;
         r_div     <= '0;
         r_p       <= '0;
         r_cnt     <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         DivByZero <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (r_state)
            S_RUN: begin
               // Start is ignored here; operands stay as latched.
               r_p   <= w_p_next;
               r_q   <= w_q_next;
               r_cnt <= r_cnt + c_ONE;
               if (r_cnt == c_LAST) begin
                  Quotient  <= w_q_next;
                  Remainder <= w_p_next;
                  DivByZero <= 1'b0;
                  Busy      <= 1'b0;
                  Done      <= 1'b1;
                  r_state   <= S_FIN;
               end
            end
            S_IDLE, S_FIN: begin
               // FIN accepts exactly like IDLE so operations can run back-to-back.
               if (Start) begin
                  r_q   <= A;
                  r_div <= B;
                  r_p   <= '0;
                  r_cnt <= '0;
                  if (B != '0) begin
                     Busy    <= 1'b1;
                     r_state <= S_RUN;
                  end else begin
                     Quotient  <= '1;
                     Remainder <= A;
                     DivByZero <= 1'b1;
                     Done      <= 1'b1;
                     r_state   <= S_FIN;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_seq
//  Description : Self-checking bench for divider_seq: directed cases with
//                literal expectations plus randomized operations checked
//                every cycle against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_seq;

   localparam int N = 8;

   logic         Clock;
   logic         Reset;
   logic         Start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         Busy;
   logic         Done;
   logic [N-1:0] Quotient;
   logic [N-1:0] Remainder;
   logic         DivByZero;

   int n_tests = 0;
   int n_fail  = 0;

   divider_seq #(.N(N)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Start     (Start),
      .A         (A),
      .B         (B),
      .Busy      (Busy),
      .Done      (Done),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivByZero (DivByZero)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (arithmetic, cycle-level timing) ------
   // mode 0 = idle, 1 = dividing, 2 = result just delivered
   int           m_mode = 0;
   int           m_left = 0;
   logic [N-1:0] m_a = '0, m_b = '0, m_pq = '0, m_pr = '0;
   logic         e_busy = 1'b0, e_done = 1'b0, e_dbz = 1'b0;
   logic [N-1:0] e_q = '0, e_r = '0;

   // Advance the model on each clock edge from the inputs seen at that edge.
   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         m_mode = 0; m_left = 0;
         e_busy = 1'b0; e_done = 1'b0; e_dbz = 1'b0; e_q = '0; e_r = '0;
      end else begin
         e_done = 1'b0;
         if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
               e_q = m_pq; e_r = m_pr; e_dbz = 1'b0;
               e_busy = 1'b0; e_done = 1'b1; m_mode = 2;
            end
         end else if (Start) begin
            m_a = A; m_b = B;
            if (B == 0) begin
               e_q = '1; e_r = A; e_dbz = 1'b1; e_done = 1'b1; m_mode = 2;
            end else begin
               m_pq = A / B; m_pr = A % B; m_left = N;
               e_busy = 1'b1; m_mode = 1;
            end
         end else begin
            m_mode = 0;
         end
      end
   end

   // Compare DUT against the model shortly after every edge.
   always @(posedge Clock) begin
      #1;
      if (!Reset) begin
         chk("busy", Busy, e_busy);
         chk("done", Done, e_done);
         chk("quotient", Quotient, e_q);
         chk("remainder", Remainder, e_r);
         chk("divbyzero", DivByZero, e_dbz);
         chk("busy_done_exclusive", Busy && Done, 0);
         if (Done && !DivByZero && m_b != 0) begin
            chk("inv_q_times_b_plus_r", longint'(Quotient) * m_b + Remainder, m_a);
            chk("inv_r_lt_b", Remainder < m_b, 1);
         end
      end
   end

   // ---------------- stimulus helpers -------------------------------------
   // Called at a negedge. Returns edges from acceptance to Done (lat) and
   // the number of cycles Busy was seen high.
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit hold, output int lat, output int busyc);
      int cnt;
      cnt   = 0;
      busyc = 0;
      A = a; B = b; Start = 1'b1;
      forever begin
         @(negedge Clock);
         cnt++;
         if (!hold) Start = 1'b0;
         A = N'($urandom);
         B = N'($urandom);
         if (Busy) busyc++;
         if (Done) break;
         if (cnt >= 40) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: got no Done, expected Done within 40 cycles");
            break;
         end
      end
      Start = 1'b0;
      lat   = cnt - 1;
      @(negedge Clock);
      chk("done_single_cycle", Done, 0);
   endtask

   task automatic op_chk(input logic [N-1:0] a, input logic [N-1:0] b,
                         input int eq, input int er, input int ed,
                         input int elat, input int ebusy);
      int lat, busyc;
      do_op(a, b, 1'b0, lat, busyc);
      chk("lit_latency", lat, elat);
      chk("lit_busy_cycles", busyc, ebusy);
      chk("lit_quotient", Quotient, eq);
      chk("lit_remainder", Remainder, er);
      chk("lit_divbyzero", DivByZero, ed);
   endtask

   // ---------------- main sequence ----------------------------------------
   initial begin
      int cnt, dones, lat, busyc;
      logic [N-1:0] ra, rb;
      bit hold;

      Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
      repeat (3) @(negedge Clock);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_quotient", Quotient, 0);
      chk("rst_remainder", Remainder, 0);
      chk("rst_divbyzero", DivByZero, 0);
      Reset = 1'b0;
      @(negedge Clock);

      op_chk(8'd200, 8'd7,   28,  4, 0, 8, 8);
      op_chk(8'd5,   8'd9,    0,  5, 0, 8, 8);
      op_chk(8'd255, 8'd1,  255,  0, 0, 8, 8);
      op_chk(8'd255, 8'd255,  1,  0, 0, 8, 8);
      op_chk(8'd37,  8'd0,  255, 37, 1, 0, 0);
      op_chk(8'd9,   8'd3,    3,  0, 0, 8, 8);

      // Start held through RUN with operands changed mid-run.
      A = 8'd100; B = 8'd10; Start = 1'b1;
      cnt = 0;
      do begin
         @(negedge Clock);
         cnt++;
         if (cnt == 3) begin A = 8'd50; B = 8'd5; end
      end while (!Done && cnt < 40);
      chk("held_latency", cnt, 9);
      chk("held_quotient", Quotient, 10);
      chk("held_remainder", Remainder, 0);
      // Start still high in FIN: 50/5 accepted back-to-back.
      cnt = 0;
      do begin
         @(negedge Clock);
         cnt++;
         if (cnt == 1) Start = 1'b0;
      end while (!Done && cnt < 40);
      chk("b2b_latency", cnt, 9);
      chk("b2b_quotient", Quotient, 10);
      chk("b2b_remainder", Remainder, 0);
      @(negedge Clock);

      // Asynchronous reset in the middle of an operation.
      A = 8'd200; B = 8'd7; Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      repeat (2) @(negedge Clock);
      chk("pre_reset_busy", Busy, 1);
      #2 Reset = 1'b1;
      #1;
      chk("async_rst_busy", Busy, 0);
      chk("async_rst_done", Done, 0);
      chk("async_rst_quotient", Quotient, 0);
      chk("async_rst_remainder", Remainder, 0);
      chk("async_rst_divbyzero", DivByZero, 0);
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      dones = 0;
      repeat (12) begin
         @(negedge Clock);
         if (Done) dones++;
      end
      chk("no_done_after_reset", dones, 0);
      op_chk(8'd200, 8'd7, 28, 4, 0, 8, 8);

      // Randomized operations, including zero dividend and zero divisor.
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge Clock);
         ra   = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
         rb   = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
         hold = ($urandom_range(0, 3) == 0);
         do_op(ra, rb, hold, lat, busyc);
         chk("rnd_latency", lat, (rb == 0) ? 0 : N);
         chk("rnd_busy_cycles", busyc, (rb == 0) ? 0 : N);
      end

      repeat (2) @(negedge Clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Sequential unsigned restoring divider, N-bit; the inverse companion to the accumulating adder/subtractor core.
- Performs division by repeated shift-and-subtract, one quotient bit per clock, controlled by a Start/Done handshake.
- Sits beside the add/sub core on the DE2 top level: operands come from switches, results go to the LEDs.

Parameters:
N, 8, operand/result width in bits (N >= 2)

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
Start  input  1  request division; sampled on the rising edge of Clock
A  input  N  dividend, unsigned; captured when Start is accepted
B  input  N  divisor, unsigned; captured when Start is accepted
Busy  output  1  high while an iteration sequence is in progress
Done  output  1  one-cycle pulse; results valid and updated
Quotient  output  N  registered quotient
Remainder  output  N  registered remainder
DivByZero  output  1  registered flag; B was 0 for the last completed operation

Behaviour:
- Reset:
  - Reset is asynchronous, active-high; clock is Clock.
  - While Reset is high, all outputs are 0 and the FSM is in IDLE.
  - An operation in progress when Reset asserts is abandoned; no Done is produced.
- States:
  - IDLE: Start=1 accepts a request.
  - RUN: iterating.
  - FIN: Done=1 for exactly one cycle, then IDLE.
  - Start in FIN is accepted exactly as in IDLE (back-to-back operation).
- Accept at edge k (Start=1 in IDLE or FIN):
  - Latch A into the dividend/quotient shift register and B into the divisor register.
  - Clear the partial remainder P (N+1 bits) and the iteration counter.
  - If B != 0: go to RUN. Busy=1 from after edge k until edge k+N.
  - If B == 0: go directly to FIN at edge k.
    - Quotient = all ones, Remainder = A, DivByZero = 1.
    - Done = 1 for the cycle after edge k.
- Each RUN edge, one iteration:
  - Shift {P, Q} left by 1.
  - Trial T = P - {0, divisor}.
  - If T >= 0 (MSB of T is 0): P <= T and Q[0] <= 1.
  - Otherwise P is unchanged and Q[0] <= 0.
  - Counter increments.
- Completion:
  - The Nth RUN edge (edge k+N) loads Quotient = Q and Remainder = P[N-1:0].
  - The same edge clears DivByZero, moves the FSM to FIN, and drops Busy.
  - Total latency: Start accepted at edge k -> Done high during cycle k+N..k+N+1.
- Start while Busy (RUN): ignored; operands are not re-latched.
- A and B may change freely after acceptance; the result depends only on the values latched at acceptance.
- Output holding:
  - Quotient, Remainder and DivByZero hold their values until the next completion.
  - They do not change during RUN.
- Invariants on every non-zero completion:
  - Quotient*B + Remainder == A.
  - Remainder < B.
- Busy and Done are never high simultaneously.

Test Plan:
- Reset, then A=200, B=7, Start pulsed 1 cycle -> Busy high 8 cycles; Done pulse on the 8th edge after acceptance; Quotient=28, Remainder=4, DivByZero=0.
- A=5, B=9 -> Quotient=0, Remainder=5; A=255, B=1 -> Quotient=255, Remainder=0; A=255, B=255 -> Quotient=1, Remainder=0.
- A=37, B=0 -> Done on the edge after acceptance, no Busy; Quotient=255, Remainder=37, DivByZero=1. A following 9/3 -> Quotient=3, Remainder=0, DivByZero=0.
- Start 100/10 with Start held high through RUN and A/B changed to 50/5 mid-run -> result Quotient=10, Remainder=0. Start still high in FIN -> new operation 50/5 accepted, Quotient=10, Remainder=0 after 8 more edges.
- Assert Reset 3 cycles into 200/7 -> all outputs 0 immediately (asynchronous, before the next edge); no Done. A new 200/7 afterwards completes correctly.
- Randomized 1000 operand pairs, including B=0 and A=0 -> check the invariants, a single-cycle Done, and that Busy and Done are never high together.
